// File: rtl/prefix_pkg.sv
// prefix_pkg
// Shared constants for the prefix adder, its checker and the benches.
//   PREFIX_WIDTH   : operand/sum width of the adder
//   PREFIX_LATENCY : adder pipeline depth in clock cycles
//   PREFIX_CNT_W   : default width of the checker's saturating counters
package prefix_pkg;

    localparam int PREFIX_WIDTH   = 32;
    localparam int PREFIX_LATENCY = 5;
    localparam int PREFIX_CNT_W   = 16;

endpackage

// File: rtl/prefix_delay_line.sv
// prefix_delay_line
// DEPTH-stage shift register carrying a valid bit plus W data bits.
// Only the valid bits are reset or cleared; the data bits simply follow.
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous active-high reset (valid bits only)
//   clear     : synchronous clear of the valid bits
//   in_valid  : valid bit entering stage 0
//   in_data   : data entering stage 0
//   out_valid : valid bit leaving the last stage
//   out_data  : data leaving the last stage
module prefix_delay_line import prefix_pkg::*; #(
    parameter int DEPTH = PREFIX_LATENCY,
    parameter int W     = PREFIX_WIDTH + 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0] valid_q;
    logic [W-1:0]     data_q [DEPTH];

    // Valid pipeline; reset and clear drop everything in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Data pipeline; contents are meaningless unless the matching valid bit is set.
    always_ff @(posedge clock) begin
        data_q[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/prefix_add_checker.sv
// prefix_add_checker
// Golden-model checker for a pipelined adder. Each accepted operand set is
// summed here, delayed by LATENCY cycles and compared with the adder output.
// Ports:
//   clock, reset (async, active-high), clear (sync)
//   in_valid, in_a, in_b, in_c       : operands presented to the adder
//   dut_sum, dut_cout                : adder result, LATENCY cycles later
//   chk_valid, mismatch              : registered per-comparison result
//   err_sticky                       : set on first mismatch
//   checked_cnt, error_cnt           : saturating counters
//   first_exp, first_got             : {cout,sum} expected/received at first mismatch
// Build option: define PREFIX_CHECKER_FIRST_ERR_EN to enable first-error capture;
// otherwise first_exp/first_got are tied to zero.
module prefix_add_checker import prefix_pkg::*; #(
    parameter int WIDTH   = PREFIX_WIDTH,
    parameter int LATENCY = PREFIX_LATENCY,
    parameter int CNT_W   = PREFIX_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic             chk_valid,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] checked_cnt,
    output logic [CNT_W-1:0] error_cnt,
    output logic [WIDTH:0]   first_exp,
    output logic [WIDTH:0]   first_got
);

    logic [WIDTH:0]   expected_d;
    logic             dl_valid;
    logic [WIDTH:0]   dl_expected;
    logic [WIDTH:0]   got;
    logic             cmp_fail;

    logic             chk_valid_q,   chk_valid_d;
    logic             mismatch_q,    mismatch_d;
    logic             err_sticky_q,  err_sticky_d;
    logic [CNT_W-1:0] checked_cnt_q, checked_cnt_d;
    logic [CNT_W-1:0] error_cnt_q,   error_cnt_d;

    // Widen before adding so the carry-out lands in the MSB.
    assign expected_d = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_c};

    prefix_delay_line #(
        .DEPTH (LATENCY),
        .W     (WIDTH + 1)
    ) u_delay (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (expected_d),
        .out_valid (dl_valid),
        .out_data  (dl_expected)
    );

    assign got      = {dut_cout, dut_sum};
    assign cmp_fail = dl_valid && (dl_expected != got);

    // Next-state for the result flags and saturating counters.
    always_comb begin
        chk_valid_d   = dl_valid;
        mismatch_d    = cmp_fail;
        err_sticky_d  = err_sticky_q | cmp_fail;
        checked_cnt_d = checked_cnt_q;
        error_cnt_d   = error_cnt_q;
        if (dl_valid && (checked_cnt_q != '1)) begin
            checked_cnt_d = checked_cnt_q + CNT_W'(1);
        end
        if (cmp_fail && (error_cnt_q != '1)) begin
            error_cnt_d = error_cnt_q + CNT_W'(1);
        end
    end

    // Clear takes priority over a comparison landing in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chk_valid_q   <= 1'b0;
            mismatch_q    <= 1'b0;
            err_sticky_q  <= 1'b0;
            checked_cnt_q <= '0;
            error_cnt_q   <= '0;
        end else if (clear) begin
            chk_valid_q   <= 1'b0;
            mismatch_q    <= 1'b0;
            err_sticky_q  <= 1'b0;
            checked_cnt_q <= '0;
            error_cnt_q   <= '0;
        end else begin
            chk_valid_q   <= chk_valid_d;
            mismatch_q    <= mismatch_d;
            err_sticky_q  <= err_sticky_d;
            checked_cnt_q <= checked_cnt_d;
            error_cnt_q   <= error_cnt_d;
        end
    end

    assign chk_valid   = chk_valid_q;
    assign mismatch    = mismatch_q;
    assign err_sticky  = err_sticky_q;
    assign checked_cnt = checked_cnt_q;
    assign error_cnt   = error_cnt_q;

`ifdef PREFIX_CHECKER_FIRST_ERR_EN
    logic [WIDTH:0] first_exp_q, first_exp_d;
    logic [WIDTH:0] first_got_q, first_got_d;

    // Capture only while the sticky flag is still clear, i.e. the first failure.
    always_comb begin
        first_exp_d = first_exp_q;
        first_got_d = first_got_q;
        if (cmp_fail && !err_sticky_q) begin
            first_exp_d = dl_expected;
            first_got_d = got;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            first_exp_q <= '0;
            first_got_q <= '0;
        end else if (clear) begin
            first_exp_q <= '0;
            first_got_q <= '0;
        end else begin
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
        end
    end

    assign first_exp = first_exp_q;
    assign first_got = first_got_q;
`else
    assign first_exp = '0;
    assign first_got = '0;
`endif

endmodule

// File: doc/prefix_add_checker.md
PREFIX_ADD_CHECKER -- requirements
Module: prefix_add_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width.
REQ-002 SHALL have parameter LATENCY, default 5, adder pipeline depth in clock cycles (1..16).
REQ-003 SHALL have parameter CNT_W, default 16, width of the checked and error counters.
REQ-004 SHALL use one clock; reset is asynchronous and active-high. Ports, in order:
  clock  input  1  rising-edge clock
  reset  input  1  asynchronous active-high reset
  clear  input  1  synchronous clear of counters, flags and the delay line
  in_valid  input  1  operands presented to the adder this cycle
  in_a  input  WIDTH  operand a
  in_b  input  WIDTH  operand b
  in_c  input  1  carry-in
  dut_sum  input  WIDTH  adder sum output
  dut_cout  input  1  adder carry-out
  chk_valid  output  1  a comparison happened this cycle
  mismatch  output  1  one-cycle pulse on a failed comparison
  err_sticky  output  1  set on the first mismatch, held until clear/reset
  checked_cnt  output  CNT_W  comparisons performed, saturating
  error_cnt  output  CNT_W  mismatches, saturating
  first_exp  output  WIDTH+1  {cout,sum} expected at the first mismatch
  first_got  output  WIDTH+1  {cout,sum} received at the first mismatch

Function
REQ-005 SHALL compute expected = in_a + in_b + in_c in WIDTH+1 bits when in_valid=1, with the MSB as the expected carry-out.
REQ-006 SHALL carry {valid, expected} through a LATENCY-stage delay line, so an entry launched at edge N is compared at edge N+LATENCY.
REQ-007 SHALL compare the delayed expected value against {dut_cout, dut_sum} only when the delayed valid is 1; the result is registered, so chk_valid and mismatch assert in the cycle after edge N+LATENCY.
REQ-008 SHALL leave counters and flags unchanged in cycles with no delayed valid; bubbles in in_valid are allowed.
REQ-009 SHALL increment checked_cnt on every comparison and error_cnt on every mismatch; both hold at all-ones (2^CNT_W-1) without wrap.
REQ-010 SHALL set err_sticky on the first mismatch; later mismatches do not alter it.
REQ-011 On clear=1, SHALL zero the counters, err_sticky, first_exp/first_got and all delay-line valid bits at the next edge; clear wins over a same-cycle comparison or launch.
REQ-012 SHALL accept one new operand set per cycle; back-to-back valid input is the normal case.

Reset
REQ-013 SHALL, while reset=1, asynchronously force all outputs to 0 and all delay-line valid bits to 0; expected data bits need no reset.
REQ-014 SHALL drop any operations in flight when reset is asserted mid-stream; no comparison follows for entries launched before reset deasserts.

Configuration
REQ-015 SHALL implement first-error capture only when macro PREFIX_CHECKER_FIRST_ERR_EN is defined: on the first mismatch (err_sticky=0), latch expected into first_exp and received into first_got.
REQ-016 Without PREFIX_CHECKER_FIRST_ERR_EN, first_exp and first_got SHALL be tied to 0 and no capture registers exist; all other behaviour is identical.

Structure
REQ-017 Shared package prefix_pkg SHALL hold PREFIX_WIDTH=32 and PREFIX_LATENCY=5 constants, used as parameter defaults by the adder, this checker and the benches.
REQ-018 The delay line SHALL be a sub-module, prefix_delay_line (parameters DEPTH, W; valid bit resettable).

Verification
REQ-019 a=10, b=20, c=0 at cycle 0; dut returns 30, cout=0 at cycle 5 -> chk_valid=1, mismatch=0, checked_cnt=1.
REQ-020 Back-to-back (56,68,1), then (156,750,1) with correct dut -> expected 125 then 907; two comparisons on consecutive cycles; error_cnt=0.
REQ-021 a=32'hFFFFFFFF, b=0, c=1; dut sum=0, cout=1 -> no mismatch. Repeat with dut cout=0 -> mismatch pulse, err_sticky=1, first_exp=33'h1_00000000, first_got=0 when the macro is defined.
REQ-022 Force CNT_W=4 with 20 failing ops -> error_cnt and checked_cnt stick at 15.
REQ-023 Launch 3 ops, assert reset at cycle 2 for one cycle -> no chk_valid for those ops; all outputs 0. Repeat with clear in place of reset -> same result, applied at the edge.
